mem_arb2: RTL and testbench
===========================

Name: mem_arb2

Overview:
- Two-requester controller for the single-port synchronous memory (registered read, 1-cycle read latency, one access per cycle).
- Arbitrates requester 0 and requester 1 round-robin and drives the memory control and data signals.
- Returns read data to the owning requester.
- Provides a hardware clear sequence that overwrites every memory location with CLEAR_VALUE.

Parameters:
- ADDR_WIDTH, 2, memory address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data width.
- CLEAR_VALUE, 8'h00, value written to every location during a clear (DATA_WIDTH bits).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mN_valid  in  1  requester N (N=0,1) has a request
- mN_ready  out  1  request N accepted this cycle
- mN_we  in  1  1=write, 0=read
- mN_addr  in  ADDR_WIDTH  request address
- mN_wdata  in  DATA_WIDTH  write data
- mN_rvalid  out  1  read response valid for requester N
- mN_rdata  out  DATA_WIDTH  read response data
- clear_req  in  1  start clear sequence (pulse)
- busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse, clear finished
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_wr_en  out  1  to memory wr_en
- mem_rd_en  out  1  to memory rd_en
- mem_wdata  out  DATA_WIDTH  to memory wdata
- mem_rdata  in  DATA_WIDTH  from memory rdata

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - Asynchronous reset forces: state=ARB, rr pointer favours m0, m0_rvalid=m1_rvalid=0, clear counter=0, clear_done=0.
  - While reset is high, mN_ready=0, mem_wr_en=0 and mem_rd_en=0.
- FSM states:
  - ARB: normal arbitration.
  - CLEAR: sequential overwrite.
- ARB state:
  - Grant:
    - Only one valid: that requester wins.
    - Both valid: the requester indicated by the rr pointer wins.
  - mN_ready is combinational: (state==ARB) && !clear_req && grant==N. At most one ready per cycle.
  - Accept = mN_valid && mN_ready.
  - On accept:
    - mem_addr=mN_addr, mem_wdata=mN_wdata.
    - mem_wr_en=mN_we, mem_rd_en=!mN_we (combinational, same cycle).
    - rr pointer moves to the other requester at the clock edge.
  - No accept: mem_wr_en=mem_rd_en=0; pointer holds.
- Read response:
  - Accepted read in cycle t: mN_rvalid=1 in cycle t+1 only (registered owner tag).
  - mN_rdata = mem_rdata. Value is don't-care when rvalid=0, but it is driven, never X-forced.
  - Back-to-back reads give rvalid on consecutive cycles, one per read, in order.
- Write then read of the same address on consecutive cycles: the read returns the new data, because the memory write commits at the edge.
- Requesters must hold valid/we/addr/wdata stable until ready. The block does not check this.
- Clear entry:
  - clear_req=1 in ARB blocks all accepts that cycle; next state=CLEAR, counter=0.
  - clear_req has priority over pending requests.
- CLEAR state:
  - busy=1, mN_ready=0.
  - Each cycle: mem_wr_en=1, mem_addr=counter, mem_wdata=CLEAR_VALUE; counter increments.
  - After counter==DEPTH-1 is written: next state=ARB, clear_done=1 for one cycle, counter returns to 0.
  - A clear takes exactly DEPTH cycles. clear_req during CLEAR is ignored.
- A read accepted in the cycle before CLEAR entry still delivers its rvalid in the first CLEAR cycle.
- Reset mid-clear aborts immediately: state=ARB, busy=0, no clear_done pulse.
  - The memory's own reset behaviour then governs its contents.
- busy is combinational from state; clear_done is registered.

Decomposition:
- Shared package mem_ctrl_pkg:
  - State enum {ARB, CLEAR}.
  - Requester-index typedef (1 bit).
  - Default width constants ADDR_WIDTH=2, DATA_WIDTH=8.
- One natural sub-module: rr_arb2.
  - Pure two-way round-robin grant logic plus pointer register.
  - Inputs: req[1:0], accept.
  - Output: grant one-hot.
- All other logic is flat in mem_arb2.

Test Plan:
1. After reset, m0 writes addr 2 data 8'hA5, then m0 reads addr 2 -> m0_ready high on both cycles; m0_rvalid=1, m0_rdata=8'hA5 in the cycle after the read; m1_rvalid stays 0.
2. m0 and m1 both hold valid reads (addr 0, addr 1) after a preload of 8'h11/8'h22 -> m0 is granted first, then m1. Responses arrive on consecutive cycles with rdata 8'h11 then 8'h22, each flagged on the correct rvalid.
3. Both requesters issue continuous writes for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; exactly one mem_wr_en per cycle.
4. Memory preloaded 8'h5A everywhere, pulse clear_req while m1_valid=1 -> m1_ready stays 0. busy=1 for 4 cycles, with mem_wr_en on addresses 0,1,2,3 and data 8'h00. clear_done pulses once; m1 is accepted on the first ARB cycle after; subsequent reads return 8'h00.
5. Assert reset during CLEAR cycle 2 -> busy=0 immediately, no clear_done, outputs at reset values. After deassert, m0 is granted first when both are valid.
6. m0 read accepted in the same cycle as clear_req=0, then clear_req=1 next cycle -> m0_rvalid=1 with correct data in the first CLEAR cycle; the clear still completes in 4 cycles.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the two-requester memory controller.
package mem_ctrl_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef logic req_idx_t;

  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/mem_arb2_if.sv
// One requester's port into the controller: request handshake plus read response.
interface mem_arb2_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) ();

  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb2_rr_arb2.sv
// Two-way round-robin grant; the pointer only advances past a winner that was accepted.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  req_idx_t ptr;
  req_idx_t win;

  always_comb begin
    win = ptr;
    if (req[0] && !req[1]) begin
      win = 1'b0;
    end else if (req[1] && !req[0]) begin
      win = 1'b1;
    end
    grant = win ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/mem_arb2.sv
// Round-robin front end for a single-port registered-read memory, with a hardware clear sweep.
// Read data returns one cycle after accept on the owner's port; clear_req preempts all requests.
module mem_arb2
  import mem_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_arb2_if.slave             m0,
  mem_arb2_if.slave             m1,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nxt;
  logic                  clear_done_nxt;

  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  accept;
  req_idx_t              sel;
  logic                  sel_we;
  logic                  ready0;
  logic                  ready1;

  logic                  rd_pend;
  req_idx_t              rd_owner;

  assign req = {m1.valid, m0.valid};
  assign sel = grant[1];

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    clear_done_nxt = 1'b0;
    ready0         = 1'b0;
    ready1         = 1'b0;
    accept         = 1'b0;
    sel_we         = sel ? m1.we : m0.we;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wr_en      = 1'b0;
    mem_rd_en      = 1'b0;

    case (state)
      ARB: begin
        mem_addr  = sel ? m1.addr  : m0.addr;
        mem_wdata = sel ? m1.wdata : m0.wdata;
        // Reset gating keeps the memory quiet while the async reset is held.
        if (!clear_req && !reset) begin
          ready0 = grant[0];
          ready1 = grant[1];
          accept = sel ? m1.valid : m0.valid;
          if (accept) begin
            mem_wr_en = sel_we;
            mem_rd_en = !sel_we;
          end
        end
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end

      CLEAR: begin
        mem_wr_en = 1'b1;
        mem_addr  = cnt;
        mem_wdata = CLEAR_VALUE;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nxt      = ARB;
          clear_done_nxt = 1'b1;
          cnt_nxt        = '0;
        end
      end

      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      cnt        <= '0;
      clear_done <= 1'b0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clear_done <= clear_done_nxt;
      rd_pend    <= mem_rd_en;
      if (mem_rd_en) begin
        rd_owner <= sel;
      end
    end
  end

  // The memory's registered read lines up with the owner tag captured at accept.
  assign m0.ready  = ready0;
  assign m1.ready  = ready1;
  assign m0.rvalid = rd_pend && (rd_owner == 1'b0);
  assign m1.rvalid = rd_pend && (rd_owner == 1'b1);
  assign m0.rdata  = mem_rdata;
  assign m1.rdata  = mem_rdata;
  assign busy      = (state == CLEAR);

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed scenarios then random traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_mem_arb2;

  localparam int         AW      = 2;
  localparam int         DW      = 8;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] CLR_VAL = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_req = 1'b0;
  logic          busy, clear_done, mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
  mem_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();

  mem_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CLR_VAL)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0),
    .m1         (m1),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pending requester stimulus (held until the model predicts acceptance).
  logic          rq_v  [2];
  logic          rq_we [2];
  logic [AW-1:0] rq_a  [2];
  logic [DW-1:0] rq_d  [2];

  // Reference model state.
  int         fav;
  bit         mdl_clr;
  int         mdl_cnt;
  bit         exp_done;
  bit         exp_rv [2];
  logic [7:0] exp_rd;
  logic [7:0] mdl_mem [DEPTH];
  int         busy_seen;
  int         done_seen;

  task automatic req(input int n, input bit we, input int a, input int d);
    rq_v[n]  = 1'b1;
    rq_we[n] = we;
    rq_a[n]  = AW'(a);
    rq_d[n]  = DW'(d);
  endtask

  task automatic model_reset();
    fav      = 0;
    mdl_clr  = 0;
    mdl_cnt  = 0;
    exp_done = 0;
    exp_rv   = '{0, 0};
    rq_v     = '{0, 0};
  endtask

  // Called #1 after a rising edge; drives one cycle, checks it, advances the model.
  task automatic step(input bit clr, output int g);
    m0.valid = rq_v[0]; m0.we = rq_we[0]; m0.addr = rq_a[0]; m0.wdata = rq_d[0];
    m1.valid = rq_v[1]; m1.we = rq_we[1]; m1.addr = rq_a[1]; m1.wdata = rq_d[1];
    clear_req = clr;
    g = -1;
    @(negedge clk);
    if (busy) busy_seen++;
    if (clear_done) done_seen++;
    if (mdl_clr) begin
      chk("clr_busy", busy, 1);
      chk("clr_m0_ready", m0.ready, 0);
      chk("clr_m1_ready", m1.ready, 0);
      chk("clr_wr_en", mem_wr_en, 1);
      chk("clr_rd_en", mem_rd_en, 0);
      chk("clr_addr", mem_addr, mdl_cnt);
      chk("clr_wdata", mem_wdata, CLR_VAL);
    end else begin
      chk("arb_busy", busy, 0);
      if (!clr) begin
        if (rq_v[0] && rq_v[1]) g = fav;
        else if (rq_v[0])      g = 0;
        else if (rq_v[1])      g = 1;
      end
      if (rq_v[0]) chk("m0_ready", m0.ready, g == 0);
      if (rq_v[1]) chk("m1_ready", m1.ready, g == 1);
      chk("wr_en", mem_wr_en, (g >= 0) && rq_we[g < 0 ? 0 : g]);
      chk("rd_en", mem_rd_en, (g >= 0) && !rq_we[g < 0 ? 0 : g]);
      if (g >= 0) begin
        chk("mem_addr", mem_addr, rq_a[g]);
        if (rq_we[g]) chk("mem_wdata", mem_wdata, rq_d[g]);
      end
    end
    chk("clear_done", clear_done, exp_done);
    chk("m0_rvalid", m0.rvalid, exp_rv[0]);
    chk("m1_rvalid", m1.rvalid, exp_rv[1]);
    if (exp_rv[0]) chk("m0_rdata", m0.rdata, exp_rd);
    if (exp_rv[1]) chk("m1_rdata", m1.rdata, exp_rd);
    @(posedge clk);
    exp_done = 0;
    exp_rv   = '{0, 0};
    if (mdl_clr) begin
      mdl_mem[mdl_cnt] = CLR_VAL;
      if (mdl_cnt == DEPTH - 1) begin
        mdl_clr  = 0;
        mdl_cnt  = 0;
        exp_done = 1;
      end else begin
        mdl_cnt++;
      end
    end else if (clr) begin
      mdl_clr = 1;
      mdl_cnt = 0;
    end else if (g >= 0) begin
      if (rq_we[g]) begin
        mdl_mem[rq_a[g]] = rq_d[g];
      end else begin
        exp_rv[g] = 1;
        exp_rd    = mdl_mem[rq_a[g]];
      end
      fav     = 1 - g;
      rq_v[g] = 1'b0;
    end
    #1;
  endtask

  // Called #1 after a rising edge; reset must dominate even with live requests.
  task automatic apply_reset();
    reset = 1'b1;
    m0.valid = 1'b1; m0.we = 1'b0;
    m1.valid = 1'b1; m1.we = 1'b1;
    clear_req = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m0_ready", m0.ready, 0);
    chk("rst_m1_ready", m1.ready, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_m0_rvalid", m0.rvalid, 0);
    chk("rst_m1_rvalid", m1.rvalid, 0);
    chk("rst_clear_done", clear_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    rq_we = '{0, 0};
    rq_a  = '{0, 0};
    rq_d  = '{0, 0};
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 'x;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Initial clear puts memory into a known state.
    busy_seen = 0; done_seen = 0;
    step(1, g);
    for (int i = 0; i < DEPTH + 1; i++) step(0, g);
    chk("init_clear_busy_cycles", busy_seen, DEPTH);
    chk("init_clear_done_pulses", done_seen, 1);

    // Write then read-back on m0.
    req(0, 1, 2, 8'hA5); step(0, g);
    req(0, 0, 2, 0);     step(0, g);
    step(0, g);

    // Both requesters read after a preload; m0 first.
    apply_reset();
    req(0, 1, 0, 8'h11); step(0, g);
    req(1, 1, 1, 8'h22); step(0, g);
    req(0, 0, 0, 0); req(1, 0, 1, 0);
    step(0, g); chk("t2_first_grant", g, 0);
    step(0, g); chk("t2_second_grant", g, 1);
    step(0, g);

    // Continuous writes from both alternate strictly.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (!rq_v[0]) req(0, 1, i % DEPTH, 8'h40 + i);
      if (!rq_v[1]) req(1, 1, (i + 1) % DEPTH, 8'h80 + i);
      step(0, g);
      chk("t3_alternate", g, i % 2);
    end
    rq_v = '{0, 0};
    step(0, g);

    // Clear preempts a pending m1 request; m1 wins straight after.
    apply_reset();
    for (int a = 0; a < DEPTH; a++) begin
      req(0, 1, a, 8'h5A); step(0, g);
    end
    req(1, 0, 2, 0);
    busy_seen = 0; done_seen = 0;
    step(1, g);
    for (int i = 0; i < DEPTH; i++) step(0, g);
    step(0, g); chk("t4_m1_after_clear", g, 1);
    chk("t4_busy_cycles", busy_seen, DEPTH);
    chk("t4_done_pulses", done_seen, 1);
    for (int a = 0; a < DEPTH; a++) begin
      req(0, 0, a, 0); step(0, g);
    end
    step(0, g);

    // Reset in the middle of a clear aborts it without a done pulse.
    apply_reset();
    busy_seen = 0; done_seen = 0;
    step(1, g);
    step(0, g);
    apply_reset();
    req(0, 0, 1, 0); req(1, 0, 2, 0);
    step(0, g); chk("t5_first_after_reset", g, 0);
    for (int i = 0; i < 3; i++) step(0, g);
    chk("t5_no_done", done_seen, 0);

    // Read accepted just before the clear request still returns its data.
    apply_reset();
    req(0, 1, 1, 8'h3C); step(0, g);
    req(0, 0, 1, 0);     step(0, g);
    busy_seen = 0; done_seen = 0;
    step(1, g);
    for (int i = 0; i < DEPTH + 1; i++) step(0, g);
    chk("t6_busy_cycles", busy_seen, DEPTH);
    chk("t6_done_pulses", done_seen, 1);

    // Random traffic with occasional clears.
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rq_v[n] && $urandom_range(0, 2) != 0)
          req(n, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      end
      step(!mdl_clr && ($urandom_range(0, 24) == 0), g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
